// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence core and its self-test feeder.
package geofence_pkg;

    localparam int COORD_W     = 10;
    localparam int PTS_PER_OBJ = 7;
    localparam int ROM_W       = 2 * COORD_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } feeder_state_t;

    typedef struct packed {
        logic               golden;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } rom_word_t;

endpackage

// File: rtl/geofence_score.sv
// Result scoring for the geofence feeder: pass/fail counters and the WAIT watchdog.
module geofence_score
    import geofence_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_tick,
    input  logic       i_valid,
    input  logic       i_is_inside,
    input  logic       i_golden,
    output logic [6:0] o_pass_cnt,
    output logic [6:0] o_fail_cnt,
    output logic       o_expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [6:0]    r_passCnt;
    logic [6:0]    r_failCnt;
    logic [TW-1:0] r_waitCnt;
    logic          w_expired;

    // The watchdog fires on the TIMEOUT-th consecutive WAIT cycle without a result.
    assign w_expired = i_tick && !i_valid && (r_waitCnt == TW'(TIMEOUT - 1));

    // The watchdog restarts whenever the feeder leaves WAIT, so each object gets a full budget.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_passCnt <= '0;
            r_failCnt <= '0;
            r_waitCnt <= '0;
        end else if (i_clear) begin
            r_passCnt <= '0;
            r_failCnt <= '0;
            r_waitCnt <= '0;
        end else if (i_tick) begin
            if (i_valid) begin
                if (i_is_inside == i_golden) begin
                    r_passCnt <= r_passCnt + 7'd1;
                end else begin
                    r_failCnt <= r_failCnt + 7'd1;
                end
                r_waitCnt <= '0;
            end else if (w_expired) begin
                r_failCnt <= r_failCnt + 7'd1;
                r_waitCnt <= '0;
            end else begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end

    assign o_pass_cnt = r_passCnt;
    assign o_fail_cnt = r_failCnt;
    assign o_expired  = w_expired;

endmodule

// File: rtl/geofence_feeder.sv
// Self-test initiator for the geofence core: streams ROM points, then scores each response.
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int NUM_OBJ = 50,
    parameter int TIMEOUT = 4096,
    parameter int AW      = 9
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [AW-1:0]      o_rom_addr,
    input  logic [ROM_W-1:0]   i_rom_data,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    input  logic               i_valid,
    input  logic               i_is_inside,
    output logic [5:0]         o_obj_idx,
    output logic [6:0]         o_pass_cnt,
    output logic [6:0]         o_fail_cnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_all_pass,
    output logic               o_timeout,
    output logic               o_proto_err
);

    feeder_state_t      r_state;
    logic [2:0]         r_ptCnt;
    logic [AW-1:0]      r_romAddr;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [5:0]         r_objIdx;
    logic               r_golden;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic               r_protoErr;

    rom_word_t          w_word;
    logic [AW-1:0]      w_objExt;
    logic [AW-1:0]      w_baseAddr;
    logic               w_accept;
    logic               w_inWait;
    logic               w_lastObj;
    logic               w_expired;
    logic [6:0]         w_passCnt;
    logic [6:0]         w_failCnt;

    assign w_word     = rom_word_t'(i_rom_data);
    assign w_objExt   = AW'(r_objIdx);
    assign w_baseAddr = (w_objExt << 3) - w_objExt;
    assign w_accept   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_inWait   = (r_state == ST_WAIT);
    assign w_lastObj  = (r_objIdx == 6'(NUM_OBJ - 1));

    // SEND spends one extra cycle (pt 0) covering ROM latency; points are captured on counts 1..7.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_ptCnt    <= '0;
            r_romAddr  <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_objIdx   <= '0;
            r_golden   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_protoErr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state    <= ST_FETCH;
                        r_objIdx   <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_protoErr <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_romAddr <= w_baseAddr;
                    r_ptCnt   <= '0;
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (r_ptCnt < 3'(PTS_PER_OBJ - 1)) begin
                        r_romAddr <= r_romAddr + 1'b1;
                    end
                    if (r_ptCnt != 3'd0) begin
                        r_x <= w_word.x;
                        r_y <= w_word.y;
                    end
                    if (r_ptCnt == 3'd1) begin
                        r_golden <= w_word.golden;
                    end
                    if (r_ptCnt == 3'(PTS_PER_OBJ)) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_ptCnt <= r_ptCnt + 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (i_valid) begin
                        if (w_lastObj) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_objIdx <= r_objIdx + 6'd1;
                            r_state  <= ST_FETCH;
                        end
                    end else if (w_expired) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (i_valid && !w_inWait) begin
                r_protoErr <= 1'b1;
            end
        end
    end

    geofence_score #(
        .TIMEOUT(TIMEOUT)
    ) u_score (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_accept),
        .i_tick     (w_inWait),
        .i_valid    (i_valid),
        .i_is_inside(i_is_inside),
        .i_golden   (r_golden),
        .o_pass_cnt (w_passCnt),
        .o_fail_cnt (w_failCnt),
        .o_expired  (w_expired)
    );

    assign o_rom_addr  = r_romAddr;
    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_obj_idx   = r_objIdx;
    assign o_pass_cnt  = w_passCnt;
    assign o_fail_cnt  = w_failCnt;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_all_pass  = r_done && (w_failCnt == 7'd0) && (w_passCnt == 7'(NUM_OBJ));
    assign o_timeout   = r_timeout;
    assign o_proto_err = r_protoErr;

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed bench for geofence_feeder: the bench plays both the pattern ROM and the geofence core.
module tb_geofence_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  romAddr;
    logic [20:0] romData = '0;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        valid = 1'b0;
    logic        isInside = 1'b0;
    logic [5:0]  objIdx;
    logic [6:0]  passCnt;
    logic [6:0]  failCnt;
    logic        busy;
    logic        done;
    logic        allPass;
    logic        timeoutFlag;
    logic        protoErr;

    logic [20:0] rom [0:511];

    int errors = 0;
    int checks = 0;
    int expPass = 0;
    int expFail = 0;

    int obj0X[7] = '{300, 100, 500, 600, 500, 100, 50};
    int obj0Y[7] = '{300, 100, 100, 300, 500, 500, 300};
    bit goldTab[3] = '{1'b1, 1'b0, 1'b1};

    geofence_feeder #(
        .NUM_OBJ(3),
        .TIMEOUT(16),
        .AW     (9)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .o_rom_addr (romAddr),
        .i_rom_data (romData),
        .o_x        (x),
        .o_y        (y),
        .i_valid    (valid),
        .i_is_inside(isInside),
        .o_obj_idx  (objIdx),
        .o_pass_cnt (passCnt),
        .o_fail_cnt (failCnt),
        .o_busy     (busy),
        .o_done     (done),
        .o_all_pass (allPass),
        .o_timeout  (timeoutFlag),
        .o_proto_err(protoErr)
    );

    always #5 clk = ~clk;

    // Synchronous pattern ROM: one cycle of read latency.
    always @(posedge clk) romData <= rom[romAddr];

    function automatic int expX(input int obj, input int p);
        if (obj == 0) return obj0X[p];
        if (obj == 1) return 100 + p;
        return 700 + 3 * p;
    endfunction

    function automatic int expY(input int obj, input int p);
        if (obj == 0) return obj0Y[p];
        if (obj == 1) return 200 + 2 * p;
        return 900 - p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive the inputs across exactly one rising edge, then release the pulses.
    task automatic applyStimulus(input logic s, input logic v, input logic ins);
        start    = s;
        valid    = v;
        isInside = ins;
        @(posedge clk);
        #1;
        start    = 1'b0;
        valid    = 1'b0;
        isInside = 1'b0;
    endtask

    // Entered just after the edge that moved the feeder into FETCH for this object.
    task automatic playObject(input int obj, input logic ins, input int extraWait,
                              input bit pokeStart, input bit pokeValid);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("addrBase", 32'(romAddr), 7 * obj);
        checkOutput("objIdx", 32'(objIdx), obj);
        applyStimulus(pokeStart, pokeValid, 1'b0);
        if (pokeValid) begin
            checkOutput("protoErrSet", 32'(protoErr), 1);
            checkOutput("passAfterSpurious", 32'(passCnt), expPass);
            checkOutput("failAfterSpurious", 32'(failCnt), expFail);
        end
        if (pokeStart) begin
            checkOutput("objIdxAfterStart", 32'(objIdx), obj);
            checkOutput("busyAfterStart", 32'(busy), 1);
        end
        for (int p = 0; p < 7; p++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("pointX%0d_%0d", obj, p), 32'(x), expX(obj, p));
            checkOutput($sformatf("pointY%0d_%0d", obj, p), 32'(y), expY(obj, p));
        end
        checkOutput("addrLast", 32'(romAddr), 7 * obj + 6);
        for (int i = 0; i < extraWait; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("holdX", 32'(x), expX(obj, 6));
            checkOutput("holdY", 32'(y), expY(obj, 6));
            checkOutput("holdBusy", 32'(busy), 1);
        end
        applyStimulus(1'b0, 1'b1, ins);
        if (ins == goldTab[obj]) expPass++;
        else expFail++;
        checkOutput("passCnt", 32'(passCnt), expPass);
        checkOutput("failCnt", 32'(failCnt), expFail);
    endtask

    task automatic checkFinal(input int pass, input int fail, input int ap);
        checkOutput("finalPass", 32'(passCnt), pass);
        checkOutput("finalFail", 32'(failCnt), fail);
        checkOutput("finalDone", 32'(done), 1);
        checkOutput("finalBusy", 32'(busy), 0);
        checkOutput("finalAllPass", 32'(allPass), ap);
    endtask

    initial begin
        logic        g;
        logic [9:0]  xv;
        logic [9:0]  yv;

        for (int i = 0; i < 512; i++) rom[i] = '0;
        for (int o = 0; o < 3; o++) begin
            for (int p = 0; p < 7; p++) begin
                g  = (p == 0) ? goldTab[o] : !goldTab[o];
                xv = 10'(expX(o, p));
                yv = 10'(expY(o, p));
                rom[7 * o + p] = {g, xv, yv};
            end
        end

        #2;
        $display("[TB] reset state");
        checkOutput("rstAddr", 32'(romAddr), 0);
        checkOutput("rstX", 32'(x), 0);
        checkOutput("rstPass", 32'(passCnt), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(done), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        $display("[TB] run A: three objects back to back, mid-run start ignored");
        expPass = 0;
        expFail = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("busyOnStart", 32'(busy), 1);
        checkOutput("doneOnStart", 32'(done), 0);
        playObject(0, 1'b1, 0, 1'b0, 1'b0);
        playObject(1, 1'b0, 0, 1'b1, 1'b0);
        playObject(2, 1'b1, 0, 1'b0, 1'b0);
        checkFinal(3, 0, 1);
        checkOutput("aProtoErr", 32'(protoErr), 0);
        checkOutput("aTimeout", 32'(timeoutFlag), 0);

        $display("[TB] run B: restart from DONE, spurious valid, mismatch, late valid");
        expPass = 0;
        expFail = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("bDoneCleared", 32'(done), 0);
        checkOutput("bPassCleared", 32'(passCnt), 0);
        playObject(0, 1'b0, 0, 1'b0, 1'b1);
        playObject(1, 1'b0, 3, 1'b0, 1'b0);
        playObject(2, 1'b1, 0, 1'b0, 1'b0);
        checkFinal(2, 1, 0);
        checkOutput("bProtoErr", 32'(protoErr), 1);

        $display("[TB] run C: watchdog expiry");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("cProtoErrCleared", 32'(protoErr), 0);
        checkOutput("cFailCleared", 32'(failCnt), 0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cAp6X", 32'(x), 50);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cTimeoutEarly", 32'(timeoutFlag), 0);
        checkOutput("cDoneEarly", 32'(done), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cTimeout", 32'(timeoutFlag), 1);
        checkFinal(0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cHoldX", 32'(x), 50);
        checkOutput("cHoldY", 32'(y), 300);
        checkOutput("cHoldDone", 32'(done), 1);
        checkOutput("cHoldFail", 32'(failCnt), 1);

        $display("[TB] run D: asynchronous reset during SEND of object 2");
        expPass = 0;
        expFail = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        playObject(0, 1'b1, 0, 1'b0, 1'b0);
        playObject(1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("dAddr", 32'(romAddr), 0);
        checkOutput("dX", 32'(x), 0);
        checkOutput("dY", 32'(y), 0);
        checkOutput("dObj", 32'(objIdx), 0);
        checkOutput("dPass", 32'(passCnt), 0);
        checkOutput("dFail", 32'(failCnt), 0);
        checkOutput("dBusy", 32'(busy), 0);
        checkOutput("dDone", 32'(done), 0);
        checkOutput("dAllPass", 32'(allPass), 0);
        checkOutput("dTimeout", 32'(timeoutFlag), 0);
        checkOutput("dProtoErr", 32'(protoErr), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        expPass = 0;
        expFail = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        playObject(0, 1'b1, 0, 1'b0, 1'b0);
        playObject(1, 1'b0, 0, 1'b0, 1'b0);
        playObject(2, 1'b1, 0, 1'b0, 1'b0);
        checkFinal(3, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
